// File: rtl/uart_pkg.sv
// Shared FSM state type, parity mode encodings and default-divisor helper
// for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic int div_default(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through read data; DEPTH must be a
// power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// FIFO-fed UART transmitter with runtime divisor, 1/2 stop bits and
// optional parity (built only when UART_TX_PARITY_EN is defined).
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    input  logic                        two_stop,
    input  logic [1:0]                  parity_mode,
    input  logic [DATA_BITS-1:0]        data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        serial_out
);
    localparam logic [DIV_WIDTH-1:0] DIV_DEF = DIV_WIDTH'(div_default(CLOCK_FREQ, BAUD_RATE));

    tx_state_e            state_q;
    logic                 serial_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 two_stop_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic [3:0]           bit_cnt_q;

    logic [DIV_WIDTH-1:0] div_eff;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 tick;
    logic                 frame_end;
    logic                 pop;
    logic                 par_en_in;
    logic                 par_bit_in;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (data_in_valid),
        .wdata_i (data_in),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        div_eff = baud_div;
        if (baud_div == '0) begin
            div_eff = DIV_DEF;
        end else if (baud_div < DIV_WIDTH'(2)) begin
            div_eff = DIV_WIDTH'(2);
        end
    end

`ifdef UART_TX_PARITY_EN
    assign par_en_in  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
    assign par_bit_in = (^fifo_rdata) ^ (parity_mode == PAR_ODD);
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
    assign par_en_in  = 1'b0;
    assign par_bit_in = 1'b0;
`endif

    assign tick      = (cnt_q == '0);
    assign frame_end = (state_q == ST_STOP) && tick && (!two_stop_q || bit_cnt_q[0]);
    // Popping at the end of a stop bit chains frames with no idle cycle.
    assign pop       = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            serial_q   <= 1'b1;
            shift_q    <= '0;
            div_q      <= DIV_DEF;
            cnt_q      <= '0;
            two_stop_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            bit_cnt_q  <= '0;
        end else if (pop) begin
            state_q    <= ST_START;
            serial_q   <= 1'b0;
            shift_q    <= fifo_rdata;
            div_q      <= div_eff;
            cnt_q      <= div_eff - 1'b1;
            two_stop_q <= two_stop;
            par_en_q   <= par_en_in;
            par_bit_q  <= par_bit_in;
            bit_cnt_q  <= '0;
        end else if (state_q != ST_IDLE) begin
            if (!tick) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                cnt_q <= div_q - 1'b1;
                case (state_q)
                    ST_START: begin
                        state_q  <= ST_DATA;
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end
                    ST_DATA: begin
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            if (par_en_q) begin
                                state_q  <= ST_PARITY;
                                serial_q <= par_bit_q;
                            end else begin
                                state_q  <= ST_STOP;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            serial_q  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        state_q  <= ST_STOP;
                        serial_q <= 1'b1;
                    end
`endif
                    ST_STOP: begin
                        if (frame_end) begin
                            state_q <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        serial_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign serial_out    = serial_q;
    assign data_in_ready = !fifo_full;
    assign busy          = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed self-checking bench for uart_tx_fifo_cfg; parity scenarios are
// included when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        two_stop;
    logic [1:0]  parity_mode;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        serial_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] push_q[$];
    logic       cap_ser  [0:1023];
    logic       cap_busy [0:1023];
    int         pushes_done;
    int         first_full_pushes;
    int         max_count;

    always #5 clk = ~clk;

    uart_tx_fifo_cfg #(
        .CLOCK_FREQ (100_000_000),
        .BAUD_RATE  (115_200),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_div      (baud_div),
        .two_stop      (two_stop),
        .parity_mode   (parity_mode),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .serial_out    (serial_out)
    );

    // Expected line level at bit position pos of a frame: start, 8 data LSB first,
    // optional parity, then stop (high).
    function automatic logic frame_level(input logic [7:0] d, input int pos,
                                         input bit par_en, input logic par_bit);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return d[pos-1];
        if (par_en && pos == 9) return par_bit;
        return 1'b1;
    endfunction

    // Holds valid high while push_q has data; samples outputs #1 after each edge.
    task automatic run(input int ncyc, input int chg_at, input logic [15:0] chg_div);
        pushes_done       = 0;
        first_full_pushes = -1;
        max_count         = 0;
        data_in_valid = (push_q.size() != 0);
        data_in       = data_in_valid ? push_q[0] : 8'h00;
        for (int n = 0; n < ncyc; n++) begin
            logic fire;
            fire = data_in_valid && data_in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                $display("push data=%h at sample %0d", push_q[0], n);
                void'(push_q.pop_front());
                pushes_done++;
            end
            data_in_valid = (push_q.size() != 0);
            data_in       = data_in_valid ? push_q[0] : 8'h00;
            cap_ser[n]  = serial_out;
            cap_busy[n] = busy;
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (!data_in_ready && first_full_pushes < 0) first_full_pushes = pushes_done;
            if (n == chg_at) baud_div = chg_div;
        end
        data_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (serial_out !== 1'b1) begin n_fail++; $display("FAIL reset_serial: observed %b, required 1", serial_out); end
        n_checks++;
        if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: observed %b, required 1", data_in_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: observed %b, required 0", busy); end
        n_checks++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: observed %0d, required 0", fifo_count); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (serial_out !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: observed %b, required 1", serial_out); end
    endtask

    task automatic test_single();
        baud_div = 16'd4; two_stop = 1'b0; parity_mode = 2'b00;
        push_q.delete(); push_q.push_back(8'hA5);
        run(42, -1, 16'd0);
        n_checks++;
        if (cap_ser[0] !== 1'b1) begin n_fail++; $display("FAIL single_latency: observed %b at fire edge, required 1", cap_ser[0]); end
        for (int b = 0; b < 10; b++) begin
            logic [15:0] obs, expv;
            obs = '0; expv = '0;
            for (int c = 0; c < 4; c++) begin
                obs[c]  = cap_ser[1 + b*4 + c];
                expv[c] = frame_level(8'hA5, b, 1'b0, 1'b0);
            end
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL single_bit%0d: observed %h, required %h", b, obs, expv); end
        end
        n_checks++;
        if (cap_busy[40] !== 1'b1) begin n_fail++; $display("FAIL single_busy40: observed %b, required 1", cap_busy[40]); end
        n_checks++;
        if (cap_busy[41] !== 1'b0) begin n_fail++; $display("FAIL single_busy41: observed %b, required 0", cap_busy[41]); end
        n_checks++;
        if (cap_ser[41] !== 1'b1) begin n_fail++; $display("FAIL single_idle: observed %b, required 1", cap_ser[41]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] chars [6];
        chars = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5A, 8'hC3};
        baud_div = 16'd4; two_stop = 1'b0; parity_mode = 2'b00;
        push_q.delete();
        for (int i = 0; i < 6; i++) push_q.push_back(chars[i]);
        run(245, -1, 16'd0);
        n_checks++;
        if (pushes_done !== 6) begin n_fail++; $display("FAIL burst_pushes: observed %0d, required 6", pushes_done); end
        n_checks++;
        if (first_full_pushes !== 5) begin n_fail++; $display("FAIL burst_full_after: observed %0d, required 5", first_full_pushes); end
        n_checks++;
        if (max_count !== 4) begin n_fail++; $display("FAIL burst_max_count: observed %0d, required 4", max_count); end
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < 10; b++) begin
                logic [15:0] obs, expv;
                obs = '0; expv = '0;
                for (int c = 0; c < 4; c++) begin
                    obs[c]  = cap_ser[1 + f*40 + b*4 + c];
                    expv[c] = frame_level(chars[f], b, 1'b0, 1'b0);
                end
                n_checks++;
                if (obs !== expv) begin n_fail++; $display("FAIL burst_f%0d_bit%0d: observed %h, required %h", f, b, obs, expv); end
            end
        end
        n_checks++;
        if (cap_busy[241] !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: observed %b, required 0", cap_busy[241]); end
    endtask

    task automatic test_two_stop();
        logic [7:0] chars [2];
        logic [5:0] stop_obs;
        chars = '{8'h55, 8'h0F};
        baud_div = 16'd3; two_stop = 1'b1; parity_mode = 2'b00;
        push_q.delete(); push_q.push_back(chars[0]); push_q.push_back(chars[1]);
        run(70, -1, 16'd0);
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 11; b++) begin
                logic [15:0] obs, expv;
                obs = '0; expv = '0;
                for (int c = 0; c < 3; c++) begin
                    obs[c]  = cap_ser[1 + f*33 + b*3 + c];
                    expv[c] = frame_level(chars[f], b, 1'b0, 1'b0);
                end
                n_checks++;
                if (obs !== expv) begin n_fail++; $display("FAIL two_stop_f%0d_bit%0d: observed %h, required %h", f, b, obs, expv); end
            end
        end
        for (int c = 0; c < 6; c++) stop_obs[c] = cap_ser[28 + c];
        n_checks++;
        if (stop_obs !== 6'h3F) begin n_fail++; $display("FAIL two_stop_len: observed %h, required 3f", stop_obs); end
        n_checks++;
        if (cap_ser[34] !== 1'b0) begin n_fail++; $display("FAIL two_stop_next_start: observed %b, required 0", cap_ser[34]); end
        n_checks++;
        if (cap_busy[67] !== 1'b0) begin n_fail++; $display("FAIL two_stop_busy_end: observed %b, required 0", cap_busy[67]); end
    endtask

    task automatic test_baud_change();
        logic [7:0] chars [2];
        int         div_f [2];
        int         base_f [2];
        chars = '{8'h3C, 8'hC5};
        div_f = '{4, 8};
        base_f = '{1, 41};
        baud_div = 16'd4; two_stop = 1'b0; parity_mode = 2'b00;
        push_q.delete(); push_q.push_back(chars[0]); push_q.push_back(chars[1]);
        run(125, 10, 16'd8);
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 10; b++) begin
                logic [15:0] obs, expv;
                obs = '0; expv = '0;
                for (int c = 0; c < div_f[f]; c++) begin
                    obs[c]  = cap_ser[base_f[f] + b*div_f[f] + c];
                    expv[c] = frame_level(chars[f], b, 1'b0, 1'b0);
                end
                n_checks++;
                if (obs !== expv) begin n_fail++; $display("FAIL baud_chg_f%0d_bit%0d: observed %h, required %h", f, b, obs, expv); end
            end
        end
        n_checks++;
        if (cap_busy[121] !== 1'b0) begin n_fail++; $display("FAIL baud_chg_busy_end: observed %b, required 0", cap_busy[121]); end
    endtask

    task automatic test_min_div();
        baud_div = 16'd1; two_stop = 1'b0; parity_mode = 2'b00;
        push_q.delete(); push_q.push_back(8'h3C);
        run(23, -1, 16'd0);
        for (int b = 0; b < 10; b++) begin
            logic [15:0] obs, expv;
            obs = '0; expv = '0;
            for (int c = 0; c < 2; c++) begin
                obs[c]  = cap_ser[1 + b*2 + c];
                expv[c] = frame_level(8'h3C, b, 1'b0, 1'b0);
            end
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL min_div_bit%0d: observed %h, required %h", b, obs, expv); end
        end
        n_checks++;
        if (cap_busy[20] !== 1'b1) begin n_fail++; $display("FAIL min_div_busy20: observed %b, required 1", cap_busy[20]); end
        n_checks++;
        if (cap_busy[21] !== 1'b0) begin n_fail++; $display("FAIL min_div_busy21: observed %b, required 0", cap_busy[21]); end
    endtask

    task automatic test_reset_mid_frame();
        baud_div = 16'd4; two_stop = 1'b0; parity_mode = 2'b00;
        push_q.delete();
        push_q.push_back(8'hF0); push_q.push_back(8'h33); push_q.push_back(8'h44);
        run(12, -1, 16'd0);
        n_checks++;
        if (serial_out !== 1'b0) begin n_fail++; $display("FAIL mid_pre_serial: observed %b, required 0", serial_out); end
        n_checks++;
        if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL mid_pre_count: observed %0d, required 2", fifo_count); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (serial_out !== 1'b1) begin n_fail++; $display("FAIL mid_rst_serial: observed %b, required 1", serial_out); end
        n_checks++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count: observed %0d, required 0", fifo_count); end
        n_checks++;
        if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: observed %b, required 1", data_in_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: observed %b, required 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_q.delete(); push_q.push_back(8'h96);
        run(42, -1, 16'd0);
        for (int b = 0; b < 10; b++) begin
            logic [15:0] obs, expv;
            obs = '0; expv = '0;
            for (int c = 0; c < 4; c++) begin
                obs[c]  = cap_ser[1 + b*4 + c];
                expv[c] = frame_level(8'h96, b, 1'b0, 1'b0);
            end
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL after_rst_bit%0d: observed %h, required %h", b, obs, expv); end
        end
        n_checks++;
        if (cap_busy[41] !== 1'b0) begin n_fail++; $display("FAIL after_rst_busy_end: observed %b, required 0", cap_busy[41]); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [1:0] modes [2];
        logic       pbits [2];
        modes = '{2'b01, 2'b10};
        pbits = '{1'b1, 1'b0};
        baud_div = 16'd4; two_stop = 1'b0;
        for (int m = 0; m < 2; m++) begin
            parity_mode = modes[m];
            push_q.delete(); push_q.push_back(8'h07);
            run(46, -1, 16'd0);
            for (int b = 0; b < 11; b++) begin
                logic [15:0] obs, expv;
                obs = '0; expv = '0;
                for (int c = 0; c < 4; c++) begin
                    obs[c]  = cap_ser[1 + b*4 + c];
                    expv[c] = frame_level(8'h07, b, 1'b1, pbits[m]);
                end
                n_checks++;
                if (obs !== expv) begin n_fail++; $display("FAIL parity_m%0d_bit%0d: observed %h, required %h", m, b, obs, expv); end
            end
            n_checks++;
            if (cap_busy[44] !== 1'b1) begin n_fail++; $display("FAIL parity_m%0d_busy44: observed %b, required 1", m, cap_busy[44]); end
            n_checks++;
            if (cap_busy[45] !== 1'b0) begin n_fail++; $display("FAIL parity_m%0d_busy45: observed %b, required 0", m, cap_busy[45]); end
        end
        parity_mode = 2'b00;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        baud_div      = 16'd4;
        two_stop      = 1'b0;
        parity_mode   = 2'b00;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_two_stop();
        test_baud_change();
        test_min_div();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
